// File: rtl/matmul_job_arbiter.sv
// Round-robin arbiter that shares one matrix multiplier among NUM_REQ requesters.
// One job in flight: accept in IDLE, pulse start, wait for done or timeout, return result.
module matmul_job_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned M          = 8,
  parameter int unsigned N          = 8,
  parameter int unsigned P          = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*M*N*DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*N*P*DATA_WIDTH-1:0]  req_b,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  input  logic [NUM_REQ-1:0]                 rsp_ready,
  output logic [M*P*DATA_WIDTH-1:0]          rsp_c,
  output logic                               mm_start,
  output logic [M*N*DATA_WIDTH-1:0]          mm_matrix_a,
  output logic [N*P*DATA_WIDTH-1:0]          mm_matrix_b,
  input  logic                               mm_done,
  input  logic [M*P*DATA_WIDTH-1:0]          mm_result_c,
  output logic                               busy,
  output logic                               timeout_err
);

  localparam int unsigned AW   = M * N * DATA_WIDTH;
  localparam int unsigned BW   = N * P * DATA_WIDTH;
  localparam int unsigned IW   = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e               state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        winner;
  logic [IW-1:0]        ptr_next;
  logic                 any_valid;
  logic [CntW-1:0]      wait_cnt;
  logic [NUM_REQ-1:0]   owner_onehot;
  int unsigned          idx;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    ptr_next = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  always_comb begin
    req_ready = '0;
    if (state == StIdle && any_valid) req_ready[winner] = 1'b1;
  end

  assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign busy         = (state != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      ptr         <= '0;
      owner       <= '0;
      wait_cnt    <= '0;
      mm_start    <= 1'b0;
      mm_matrix_a <= '0;
      mm_matrix_b <= '0;
      rsp_valid   <= '0;
      rsp_c       <= '0;
      timeout_err <= 1'b0;
    end else begin
      mm_start <= 1'b0;
      unique case (state)
        StIdle: begin
          if (any_valid) begin
            mm_matrix_a <= req_a[winner*AW +: AW];
            mm_matrix_b <= req_b[winner*BW +: BW];
            owner       <= winner;
            ptr         <= ptr_next;
            mm_start    <= 1'b1;
            state       <= StLaunch;
          end
        end
        // Any done still high here belongs to the previous job.
        StLaunch: begin
          wait_cnt <= '0;
          state    <= StWait;
        end
        StWait: begin
          if (mm_done) begin
            rsp_c     <= mm_result_c;
            rsp_valid <= owner_onehot;
            state     <= StResp;
          end else if (wait_cnt == CntW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            rsp_c       <= '0;
            rsp_valid   <= owner_onehot;
            state       <= StResp;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// Directed bench for matmul_job_arbiter with a behavioural multiplier stub.
module tb_matmul_job_arbiter;
  localparam int DW = 8;
  localparam int M  = 8;
  localparam int N  = 8;
  localparam int P  = 8;
  localparam int NR = 4;
  localparam int TO = 16;
  localparam int AW = M * N * DW;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*AW-1:0] req_a, req_b;
  logic [AW-1:0]    rsp_c, mm_matrix_a, mm_matrix_b, mm_result_c;
  logic             mm_start, mm_done, busy, timeout_err;

  int total = 0;
  int bad   = 0;

  bit stub_en  = 1'b1;
  int stub_lat = 3;
  int stub_cnt;

  always #5 clk = ~clk;

  matmul_job_arbiter #(
    .DATA_WIDTH(DW), .M(M), .N(N), .P(P), .NUM_REQ(NR), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
    .mm_start(mm_start), .mm_matrix_a(mm_matrix_a), .mm_matrix_b(mm_matrix_b),
    .mm_done(mm_done), .mm_result_c(mm_result_c),
    .busy(busy), .timeout_err(timeout_err)
  );

  function automatic logic [AW-1:0] matmul(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW-1:0] c;
    logic [DW-1:0] s;
    logic [DW-1:0] x, y;
    c = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++) begin
        s = '0;
        for (int k = 0; k < N; k++) begin
          x = a[(i*N+k)*DW +: DW];
          y = b[(k*P+j)*DW +: DW];
          s = s + x * y;
        end
        c[(i*P+j)*DW +: DW] = s;
      end
    return c;
  endfunction

  // Multiplier stub: done rises stub_lat+1 cycles after start and stays high until next start.
  always @(posedge clk) begin
    if (rst) begin
      mm_done     <= 1'b0;
      mm_result_c <= '0;
      stub_cnt    <= 0;
    end else if (mm_start) begin
      mm_done  <= 1'b0;
      stub_cnt <= stub_lat;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && stub_en) begin
        mm_done     <= 1'b1;
        mm_result_c <= matmul(mm_matrix_a, mm_matrix_b);
      end
    end
  end

  function automatic logic [AW-1:0] diag(input int v);
    logic [AW-1:0] r = '0;
    for (int i = 0; i < M; i++) r[(i*N+i)*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [AW-1:0] fill(input int v);
    logic [AW-1:0] r;
    for (int i = 0; i < M*N; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [AW-1:0] ramp(input int s);
    logic [AW-1:0] r;
    for (int k = 0; k < M; k++)
      for (int j = 0; j < N; j++) r[(k*N+j)*DW +: DW] = DW'(s * (8*k + j));
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    stub_en   = 1'b1;
    stub_lat  = 3;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic [AW-1:0] b);
    req_valid[p]      = 1'b1;
    req_a[p*AW +: AW] = a;
    req_b[p*AW +: AW] = b;
  endtask

  // Returns just before the handshake edge.
  task automatic wait_grant(output logic [NR-1:0] g);
    g = '0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (req_ready != '0) begin
        g = req_ready;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_rsp(output logic [NR-1:0] v, output logic [AW-1:0] c);
    v = '0;
    c = '0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid != '0) begin
        v = rsp_valid;
        c = rsp_c;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    total++; if (rsp_c !== '0) begin bad++; $display("FAIL reset_rsp_c got %h want 0", rsp_c); end
    total++; if (mm_start !== 1'b0) begin bad++; $display("FAIL reset_mm_start got %b want 0", mm_start); end
    total++; if (mm_matrix_a !== '0 || mm_matrix_b !== '0) begin bad++; $display("FAIL reset_operands got %h want 0", mm_matrix_a | mm_matrix_b); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
  endtask

  task automatic test_single;
    logic [NR-1:0] g;
    int i;
    do_reset();
    set_req(0, diag(1), ramp(1));
    wait_grant(g);
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL single_grant got %b want 0001", g); end
    tick();
    req_valid = '0;
    total++; if (mm_start !== 1'b1) begin bad++; $display("FAIL single_start_t1 got %b want 1", mm_start); end
    total++; if (mm_matrix_b !== ramp(1)) begin bad++; $display("FAIL single_operand_b got %h want %h", mm_matrix_b, ramp(1)); end
    tick();
    total++; if (mm_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_start_t2 got start=%b busy=%b want 0 1", mm_start, busy); end
    for (i = 0; i < 50; i++) begin
      if (mm_done) break;
      tick();
    end
    total++; if (i == 50) begin bad++; $display("FAIL single_done_wait got none want done"); end
    total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL single_rsp_at_d got %b want 0", rsp_valid); end
    tick();
    total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL single_rsp_d1 got %b want 0001", rsp_valid); end
    total++; if (rsp_c !== ramp(1)) begin bad++; $display("FAIL single_rsp_c got %h want %h", rsp_c, ramp(1)); end
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    total++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_after_ack got v=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_two_ports;
    logic [NR-1:0] g, v;
    logic [AW-1:0] c;
    do_reset();
    set_req(1, fill(1), fill(2));
    set_req(3, diag(2), diag(1));
    wait_grant(g);
    total++; if (g !== 4'b0010) begin bad++; $display("FAIL two_first_grant got %b want 0010", g); end
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(v, c);
    total++; if (v !== 4'b0010) begin bad++; $display("FAIL two_rsp1_valid got %b want 0010", v); end
    total++; if (c !== fill(16)) begin bad++; $display("FAIL two_rsp1_c got %h want %h", c, fill(16)); end
    rsp_ready = 4'b1010;
    tick();
    rsp_ready = '0;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL two_second_grant got %b want 1000", req_ready); end
    tick();
    req_valid[3] = 1'b0;
    wait_rsp(v, c);
    total++; if (v !== 4'b1000) begin bad++; $display("FAIL two_rsp3_valid got %b want 1000", v); end
    total++; if (c !== diag(2)) begin bad++; $display("FAIL two_rsp3_c got %h want %h", c, diag(2)); end
    rsp_ready = 4'b1000;
    tick();
    rsp_ready = '0;
  endtask

  task automatic test_round_robin;
    logic [NR-1:0] g, v;
    logic [AW-1:0] c;
    int exp;
    do_reset();
    for (int p = 0; p < NR; p++) set_req(p, diag(p + 1), diag(1));
    for (int j = 0; j < 8; j++) begin
      exp = j % NR;
      wait_grant(g);
      total++; if (g !== NR'(1 << exp)) begin bad++; $display("FAIL rr_grant_%0d got %b want %b", j, g, NR'(1 << exp)); end
      tick();
      wait_rsp(v, c);
      #1;
      total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rr_ready_in_resp_%0d got %b want 0", j, req_ready); end
      total++; if (v !== NR'(1 << exp)) begin bad++; $display("FAIL rr_rsp_valid_%0d got %b want %b", j, v, NR'(1 << exp)); end
      total++; if (c !== diag(exp + 1)) begin bad++; $display("FAIL rr_rsp_c_%0d got %h want %h", j, c, diag(exp + 1)); end
      rsp_ready = v;
      tick();
      rsp_ready = '0;
    end
  endtask

  task automatic test_backpressure;
    logic [NR-1:0] g, v;
    logic [AW-1:0] c;
    do_reset();
    set_req(0, ramp(1), diag(2));
    wait_grant(g);
    tick();
    req_valid[0] = 1'b0;
    set_req(1, diag(1), diag(1));
    wait_rsp(v, c);
    for (int i = 0; i < 20; i++) begin
      total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL bp_valid_%0d got %b want 0001", i, rsp_valid); end
      total++; if (rsp_c !== ramp(2)) begin bad++; $display("FAIL bp_rsp_c_%0d got %h want %h", i, rsp_c, ramp(2)); end
      total++; if (req_ready !== 4'b0 || busy !== 1'b1) begin bad++; $display("FAIL bp_ready_busy_%0d got %b/%b want 0000/1", i, req_ready, busy); end
      tick();
    end
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_next_grant got %b want 0010", req_ready); end
  endtask

  task automatic test_timeout;
    logic [NR-1:0] g, v;
    logic [AW-1:0] c;
    do_reset();
    // done lands on the last WAIT cycle: done wins, no abort
    stub_lat = 15;
    set_req(0, diag(3), diag(1));
    wait_grant(g);
    tick();
    req_valid = '0;
    repeat (16) tick();
    total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL to_edge_early got %b want 0", rsp_valid); end
    tick();
    total++; if (rsp_valid !== 4'b0001 || timeout_err !== 1'b0) begin bad++; $display("FAIL to_edge_done got v=%b err=%b want 0001 0", rsp_valid, timeout_err); end
    total++; if (rsp_c !== diag(3)) begin bad++; $display("FAIL to_edge_c got %h want %h", rsp_c, diag(3)); end
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    stub_en = 1'b0;
    set_req(2, fill(1), fill(1));
    wait_grant(g);
    total++; if (g !== 4'b0100) begin bad++; $display("FAIL to_grant got %b want 0100", g); end
    tick();
    req_valid = '0;
    repeat (16) tick();
    total++; if (timeout_err !== 1'b0 || rsp_valid !== 4'b0) begin bad++; $display("FAIL to_early got err=%b v=%b want 0 0000", timeout_err, rsp_valid); end
    tick();
    total++; if (timeout_err !== 1'b1 || rsp_valid !== 4'b0100) begin bad++; $display("FAIL to_fire got err=%b v=%b want 1 0100", timeout_err, rsp_valid); end
    total++; if (rsp_c !== '0) begin bad++; $display("FAIL to_rsp_c got %h want 0", rsp_c); end
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = '0;
    stub_en  = 1'b1;
    stub_lat = 3;
    set_req(1, fill(1), fill(1));
    wait_grant(g);
    tick();
    req_valid = '0;
    wait_rsp(v, c);
    total++; if (v !== 4'b0010 || c !== fill(8)) begin bad++; $display("FAIL to_next_job got v=%b c=%h want 0010 %h", v, c, fill(8)); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky got %b want 1", timeout_err); end
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = '0;
  endtask

  task automatic test_reset_mid;
    logic [NR-1:0] g;
    bool_loop: begin end
    do_reset();
    stub_lat = 10;
    set_req(0, diag(1), diag(1));
    wait_grant(g);
    tick();
    req_valid = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (mm_start !== 1'b0 || rsp_valid !== 4'b0) begin bad++; $display("FAIL mid_outputs got start=%b v=%b want 0 0000", mm_start, rsp_valid); end
    total++; if (busy !== 1'b0 || mm_matrix_a !== '0) begin bad++; $display("FAIL mid_state got busy=%b a=%h want 0 0", busy, mm_matrix_a); end
    for (int i = 0; i < 12; i++) begin
      total++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_quiet_%0d got v=%b busy=%b want 0000 0", i, rsp_valid, busy); end
      tick();
    end
    set_req(0, diag(1), diag(1));
    set_req(1, diag(1), diag(1));
    wait_grant(g);
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL mid_ptr_reset got %b want 0001", g); end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_single();
    test_two_ports();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matmul_job_arbiter.md
# matmul_job_arbiter

Shares one `matrix_multiplier` instance among `NUM_REQ` requesters. Each request carries a full A and B operand pair. The block grants requests round-robin, latches the winner's operands, and drives the multiplier's `start`/`done` protocol. It then returns the product to the granted requester over a valid/ready response channel. It sits between the requesting engines and the systolic multiplier, and is the only module that drives the multiplier's `start`.

## Interface
- `DATA_WIDTH`, 8, element width (two's complement)
- `M`, `N`, `P`, 8/8/8, A is MxN, B is NxP, C is MxP
- `NUM_REQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 1024, max cycles in WAIT before abort
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester job valid
- `req_ready`  out  NUM_REQ  per-requester job accept, one-hot or zero
- `req_a`  in  NUM_REQ*M*N*DATA_WIDTH  requester i occupies slice i, row-major packed
- `req_b`  in  NUM_REQ*N*P*DATA_WIDTH  same packing
- `rsp_valid`  out  NUM_REQ  one-hot result valid to the granted requester
- `rsp_ready`  in  NUM_REQ  per-requester result accept
- `rsp_c`  out  M*P*DATA_WIDTH  result, shared bus, row-major packed
- `mm_start`  out  1  one-cycle start pulse to the multiplier
- `mm_matrix_a` / `mm_matrix_b`  out  packed operands, registered
- `mm_done`  in  1  multiplier completion
- `mm_result_c`  in  M*P*DATA_WIDTH  multiplier result
- `busy`  out  1  high whenever the state is not IDLE
- `timeout_err`  out  1  sticky abort flag

## Operation
- FSM states:
  - IDLE: if any `req_valid` is high, grant winner w. `req_ready[w]`=1 combinationally in the same cycle. On handshake, latch `req_a`/`req_b` slice w into `mm_matrix_a`/`mm_matrix_b`, store w, and go to LAUNCH.
  - LAUNCH: `mm_start`=1 for exactly this cycle, then go to WAIT.
  - WAIT: on the first cycle `mm_done`=1, latch `mm_result_c` into `rsp_c` and go to RESP. If the WAIT cycle counter reaches `TIMEOUT`, set `timeout_err`, load `rsp_c`=0, and go to RESP.
  - RESP: `rsp_valid[w]`=1 and `rsp_c` is held stable. On `rsp_ready[w]`, go to IDLE. `rsp_ready` of non-granted requesters is ignored.
- Round-robin:
  - Pointer `ptr` resets to 0.
  - The winner is the first index at or after `ptr` (mod NUM_REQ) with `req_valid` high.
  - After each accepted request, `ptr` is set to w+1 (mod NUM_REQ).
  - `ptr` does not advance on idle cycles.
- Operand registers hold from LAUNCH until the next accepted request; they are not cleared on completion.
- `mm_done` is treated as a level. It is ignored in IDLE, LAUNCH and RESP; in particular, a stale `done` that is still high in LAUNCH is ignored.
- Only one job is in flight; no request is accepted outside IDLE.
- `timeout_err` clears only on `rst`. Later jobs proceed normally.
- No arithmetic is performed; results pass through bit-exact (the multiplier truncates C to `DATA_WIDTH`).

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_c`=0, `mm_start`=0, `mm_matrix_a`/`b`=0, `busy`=0, `timeout_err`=0, state IDLE, `ptr`=0, WAIT counter 0.
- Request accepted at cycle T:
  - `mm_start`=1 at T+1.
  - WAIT begins at T+2.
- `mm_done` seen at cycle D: `rsp_valid` and `rsp_c` are valid at D+1.
- Response handshake at cycle R: IDLE at R+1. The earliest next accept is R+1, giving one dead cycle per job.
- Timeout: the counter starts at 0 on WAIT entry. The abort fires on the cycle the counter equals `TIMEOUT`-1 with `mm_done` low. `mm_done` in that same cycle wins and no timeout is flagged.
- Reset mid-operation: the in-flight job is dropped with no response. `mm_start` and `rsp_valid` are low in the cycle after `rst`. The multiplier shares `rst`.
- A requester that drops `req_valid` before its handshake is not granted; there is no lock.

## Test plan
- Single request on port 0: A=identity, B[k][j]=8k+j → `mm_start` pulses at T+1; `rsp_valid`=4'b0001 one cycle after `mm_done`; `rsp_c`==B.
- Ports 1 and 3 valid together at reset (`ptr`=0) → port 1 is served first, then port 3. Each gets its own product (A all 1s, B all 2s → every C element 16 for port 1; A=2·I, B=I → C=2·I for port 3).
- All four ports held valid for 8 jobs → grant order 0,1,2,3,0,1,2,3; `req_ready` is never multi-hot.
- Response backpressure: hold `rsp_ready[0]`=0 for 20 cycles → `rsp_valid[0]` and `rsp_c` are held stable, `req_ready` stays 0, `busy`=1 throughout.
- Timeout with `TIMEOUT`=16 and a stub that never asserts `done` → `timeout_err`=1 at WAIT cycle 16, `rsp_c`=0 is delivered, and the next job completes normally with `timeout_err` still 1.
- `rst` asserted for 1 cycle during WAIT → all outputs reach reset values, no `rsp_valid`, and `ptr`=0 so port 0 wins the next arbitration.
